// File: rtl/qsys_sysid_checker.sv
// Avalon-MM read master: reads system-ID word (addr 0) and timestamp (addr 1),
// compares them to build-time constants and reports pass/fail/timeout.
// Latency: 3 cycles start->done with a zero-wait slave, +N per wait state.
// Backpressure: holds address/read stable under waitrequest; aborts a read
// after TIMEOUT_CYCLES stalled edges.
module qsys_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd170,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1603623072,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2
  } state_t;

  // A stalled edge with the counter at LAST is the TIMEOUT_CYCLES-th stall.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        addr_q, addr_d;
  logic        read_q, read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] read_id_q, read_id_d;
  logic [31:0] read_ts_q, read_ts_d;

  // Next-state and registered-output logic for the two back-to-back reads.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    read_d    = read_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    id_ok_d   = id_ok_q;
    ts_ok_d   = ts_ok_q;
    timeout_d = timeout_q;
    read_id_d = read_id_q;
    read_ts_d = read_ts_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          read_id_d = 32'd0;
          read_ts_d = 32'd0;
          addr_d    = 1'b0;
          read_d    = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = 16'd0;
          state_d   = RD_ID;
        end
      end
      RD_ID: begin
        // Acceptance wins over the timeout limit on the same edge.
        if (!avm_waitrequest) begin
          read_id_d = avm_readdata;
          id_ok_d   = (avm_readdata == EXPECTED_ID);
          addr_d    = 1'b1;
          cnt_d     = 16'd0;
          state_d   = RD_TS;
        end else if (cnt_q == CNT_LAST) begin
          read_d    = 1'b0;
          addr_d    = 1'b0;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cnt_d     = 16'd0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          read_ts_d = avm_readdata;
          ts_ok_d   = (avm_readdata == EXPECTED_TIMESTAMP);
          read_d    = 1'b0;
          addr_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cnt_d     = 16'd0;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          read_d    = 1'b0;
          addr_d    = 1'b0;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cnt_d     = 16'd0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        read_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight read immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      addr_q    <= 1'b0;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      read_id_q <= 32'd0;
      read_ts_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      timeout_q <= timeout_d;
      read_id_q <= read_id_d;
      read_ts_q <= read_ts_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign read_id     = read_id_q;
  assign read_ts     = read_ts_q;

endmodule

// File: tb/tb_qsys_sysid_checker.sv
// Bench for qsys_sysid_checker: table of slave behaviours with expected
// results, a scoreboard popped on each done pulse, and hand-written
// sequences for ignored starts, start-in-done-cycle and mid-read reset.
module tb_qsys_sysid_checker;

  localparam logic [31:0] EID = 32'd170;
  localparam logic [31:0] ETS = 32'd1603623072;
  localparam int          TO  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] read_id, read_ts;

  qsys_sysid_checker #(
    .EXPECTED_ID       (EID),
    .EXPECTED_TIMESTAMP(ETS),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .done           (done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout        (timeout),
    .read_id        (read_id),
    .read_ts        (read_ts)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave model: fixed wait states per address, then data.
  logic [31:0] s_id = 32'd0, s_ts = 32'd0;
  int          s_wid = 0, s_wts = 0;
  int          wcnt = 0;
  logic        wr_c;

  always_comb begin
    wr_c = 1'b0;
    if (avm_read) wr_c = (wcnt < (avm_address ? s_wts : s_wid));
  end
  assign avm_waitrequest = wr_c;
  assign avm_readdata    = avm_address ? s_ts : s_id;

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end

  // Scoreboard.
  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        to;
    logic [31:0] rid;
    logic [31:0] rts;
    int          start_cyc;
    int          lat;
    int          rdc;
  } exp_t;

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    int          wid;
    int          wts;
    logic        id_ok;
    logic        ts_ok;
    logic        to;
    logic [31:0] rid;
    logic [31:0] rts;
    int          lat;
    int          rdc;
  } vec_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   rd_cnt = 0;
  logic prev_stall = 1'b0;
  logic prev_addr  = 1'b0;

  always @(posedge clock) begin
    cyc        <= cyc + 1;
    prev_stall <= avm_read && avm_waitrequest && !reset;
    prev_addr  <= avm_address;
  end

  // Output monitor: Avalon hold rule, read-strobe length, result check on done.
  always @(negedge clock) begin
    if (reset) begin
      rd_cnt = 0;
    end else begin
      if (prev_stall && !done) begin
        chk("stall_read_held", 32'(avm_read), 32'd1);
        chk("stall_addr_held", 32'(avm_address), 32'(prev_addr));
      end
      if (avm_read) rd_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("id_ok", 32'(id_ok), 32'(e.id_ok));
          chk("ts_ok", 32'(ts_ok), 32'(e.ts_ok));
          chk("timeout", 32'(timeout), 32'(e.to));
          chk("read_id", read_id, e.rid);
          chk("read_ts", read_ts, e.rts);
          chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
          chk("read_cycles", 32'(rd_cnt), 32'(e.rdc));
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("read_at_done", 32'(avm_read), 32'd0);
        end
        rd_cnt = 0;
      end
    end
  end

  function automatic exp_t mk(input vec_t v, input int sc);
    exp_t e;
    e.id_ok = v.id_ok; e.ts_ok = v.ts_ok; e.to = v.to;
    e.rid = v.rid; e.rts = v.rts; e.start_cyc = sc; e.lat = v.lat; e.rdc = v.rdc;
    return e;
  endfunction

  task automatic set_slave(input vec_t v);
    s_id = v.id; s_ts = v.ts; s_wid = v.wid; s_wts = v.wts;
  endtask

  task automatic wait_empty(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_wait: got no done after %0d cycles expected done", name, budget);
      sb.delete();
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    set_slave(v);
    @(negedge clock);
    start = 1'b1;
    sb.push_back(mk(v, cyc));
    @(negedge clock);
    start = 1'b0;
    wait_empty(name, 60);
    // Results must persist while idle.
    @(negedge clock);
    @(negedge clock);
    chk({name, "_hold_id_ok"}, 32'(id_ok), 32'(v.id_ok));
    chk({name, "_hold_ts_ok"}, 32'(ts_ok), 32'(v.ts_ok));
    chk({name, "_hold_to"}, 32'(timeout), 32'(v.to));
    chk({name, "_hold_rid"}, read_id, v.rid);
    chk({name, "_hold_done"}, 32'(done), 32'd0);
  endtask

  vec_t tv[8];

  initial begin
    tv[0] = '{EID,   ETS,           0,  0,  1'b1, 1'b1, 1'b0, EID,   ETS,           3, 2};
    tv[1] = '{EID,   32'h12345678,  0,  0,  1'b1, 1'b0, 1'b0, EID,   32'h12345678,  3, 2};
    tv[2] = '{EID,   ETS,           3,  3,  1'b1, 1'b1, 1'b0, EID,   ETS,           9, 8};
    tv[3] = '{32'hDEAD, ETS,        0,  1,  1'b0, 1'b1, 1'b0, 32'hDEAD, ETS,        4, 3};
    tv[4] = '{EID,   ETS,           99, 0,  1'b0, 1'b0, 1'b1, 32'd0, 32'd0,         5, 4};
    tv[5] = '{EID,   ETS,           0,  99, 1'b1, 1'b0, 1'b1, EID,   32'd0,         6, 5};
    tv[6] = '{EID,   ETS,           4,  0,  1'b0, 1'b0, 1'b1, 32'd0, 32'd0,         5, 4};
    tv[7] = '{EID,   ETS,           1,  3,  1'b1, 1'b1, 1'b0, EID,   ETS,           7, 6};

    // Reset state.
    #12;
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
    chk("rst_data", read_id | read_ts, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) apply(tv[i], $sformatf("vec%0d", i));

    // Starts while busy are dropped; a start in the done cycle is taken.
    begin
      vec_t v;
      v = '{EID, ETS, 2, 2, 1'b1, 1'b1, 1'b0, EID, ETS, 7, 6};
      set_slave(v);
      @(negedge clock);
      start = 1'b1;
      sb.push_back(mk(v, cyc));
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 20 && !(avm_read && avm_address); i++) @(negedge clock);
      chk("in_rd_ts", 32'(avm_read && avm_address), 32'd1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 20 && !done; i++) @(negedge clock);
      chk("first_done_seen", 32'(done), 32'd1);
      start = 1'b1;
      sb.push_back(mk(v, cyc));
      @(negedge clock);
      start = 1'b0;
      chk("restart_read", 32'(avm_read), 32'd1);
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_addr", 32'(avm_address), 32'd0);
      chk("restart_cleared", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
      wait_empty("restart", 40);
      repeat (10) @(negedge clock);
    end

    // Reset while the timestamp read is stalled.
    begin
      vec_t v;
      v = '{EID, ETS, 0, 3, 1'b1, 1'b1, 1'b0, EID, ETS, 6, 5};
      set_slave(v);
      @(negedge clock);
      start = 1'b1;
      sb.push_back(mk(v, cyc));
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 20 && !(avm_read && avm_address); i++) @(negedge clock);
      chk("pre_rst_in_rd_ts", 32'(avm_read && avm_address), 32'd1);
      #1 reset = 1'b1;
      sb.delete();
      #1;
      chk("mrst_read", 32'(avm_read), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_addr", 32'(avm_address), 32'd0);
      chk("mrst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
      chk("mrst_rid", read_id, 32'd0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      apply(tv[0], "post_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qsys_sysid_checker.md
Name: qsys_sysid_checker

Overview:
- Avalon-MM read master that interrogates the system-ID slave.
- Reads the ID word at word address 0 and the timestamp word at word address 1.
- Compares both against build-time expected values and reports pass/fail/timeout to boot or debug logic.
- Sits on the same Qsys interconnect as the system-ID slave. It is triggered by a start pulse and does not depend on the slave's latency.

Parameters:
- EXPECTED_ID, 32'd170, value required at word address 0.
- EXPECTED_TIMESTAMP, 32'd1603623072, value required at word address 1.
- TIMEOUT_CYCLES, 255, maximum cycles one read may be stalled by waitrequest before abort; legal range 1..65535.

Ports:
- clock  input  1  single system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a check; sampled only in IDLE.
- avm_address  output  1  word address: 0 = ID, 1 = timestamp.
- avm_read  output  1  Avalon-MM read strobe.
- avm_readdata  input  32  read data; valid when avm_read=1 and avm_waitrequest=0.
- avm_waitrequest  input  1  slave stall.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at completion (pass, fail or timeout).
- id_ok  output  1  captured ID equals EXPECTED_ID.
- ts_ok  output  1  captured timestamp equals EXPECTED_TIMESTAMP.
- timeout  output  1  last check aborted on a stalled read.
- read_id  output  32  captured ID word.
- read_ts  output  32  captured timestamp word.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Applies immediately (asynchronous).
- Reset mid-read: avm_read drops at once, captured data is discarded, and no done pulse is generated.
- States:
  - IDLE: avm_read=0, busy=0. If start=1 at an edge: clear id_ok/ts_ok/timeout/read_id/read_ts, set avm_address=0, avm_read=1, busy=1, go to RD_ID.
  - RD_ID: hold avm_read=1 and avm_address=0 stable while avm_waitrequest=1. On an edge with waitrequest=0: capture read_id, set id_ok=(readdata==EXPECTED_ID), set avm_address=1 with avm_read kept high (back-to-back read), reset counter, go to RD_TS.
  - RD_TS: same hold rule. On acceptance: capture read_ts, set ts_ok, avm_read=0, busy=0, done=1 for one cycle, go to IDLE.
- Timeout counter (16 bit):
  - Cleared on entry to each read state.
  - Increments on each edge where the read is stalled.
  - When it reaches TIMEOUT_CYCLES while waitrequest=1 at that edge: avm_read=0, timeout=1, busy=0, done=1, go to IDLE.
  - On timeout, the result registers not yet read stay 0 and their ok flags stay 0.
  - Acceptance on the same edge as the limit counts as success, not timeout.
- Latency with zero-wait slave: start sampled at edge E0; ID captured at E1; timestamp captured at E2; done high in the cycle after E2.
- With N wait states per read, latency grows by N per read.
- Start handling:
  - start while busy is ignored and is not queued.
  - start=1 in the done cycle is accepted, because the state is already IDLE.
  - A held start retriggers back-to-back checks.
- Result flags and data hold their values until the next accepted start or reset.
- The Avalon rule "address stable while waitrequest" must never be violated. avm_read never glitches between reads in a sequence.

Test Plan:
- Zero-wait slave returning 170 / 1603623072; start pulse → avm_read high for exactly 2 cycles (address 0 then 1); done in 3rd cycle after start; id_ok=1, ts_ok=1, timeout=0.
- Slave returns 170 / 0x12345678 → done, id_ok=1, ts_ok=0, read_ts=32'h12345678.
- Slave inserts 3 wait states on each read → address/read stable during stalls; done 9 cycles after start; both ok=1.
- TIMEOUT_CYCLES=4, waitrequest stuck high on ID read → read drops after 4 stalled edges; done=1, timeout=1, id_ok=0, read_id=0.
- start pulses during RD_ID and RD_TS → ignored, only one done. Then start in done cycle → new sequence begins the next cycle.
- reset asserted while avm_read=1 in RD_TS → all outputs 0 immediately, no done pulse. After release, start works normally.
